// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way data cache miss controller.
// Address split: {tag[23:0], index[2:0], offset[4:0]}.
package cache_pkg;

  localparam int unsigned TAG_W     = 24;
  localparam int unsigned INDEX_W   = 3;
  localparam int unsigned OFFSET_W  = 5;
  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [1:0] {
    LOOKUP,
    WB,
    FILL,
    INSTALL
  } ctrl_state_t;

endpackage

// File: rtl/cache_line_buf.sv
// Line buffer shared by writeback and fill: whole-line load from the cache,
// per-beat word write from memory, per-beat word read for writeback data.
module cache_line_buf
  import cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  localparam int unsigned BEAT_W    = $clog2(LINE_WORDS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 word_we,
  input  logic [BEAT_W-1:0]    word_idx,
  input  logic [WORD_W-1:0]    word_wdata,
  output logic [WORD_W-1:0]    word_rdata,
  output logic [LINE_BITS-1:0] line
);

  logic [LINE_BITS-1:0] line_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_line;
    end else if (word_we) begin
      line_q[word_idx*WORD_W +: WORD_W] <= word_wdata;
    end
  end

  assign word_rdata = line_q[word_idx*WORD_W +: WORD_W];
  assign line       = line_q;

endmodule

// File: rtl/cache_controller.sv
// Miss-handling FSM for the 2-way data cache: single-cycle hits, stalled
// dirty-victim writeback and line fill over a 32-bit beat-handshake port.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [31:0]          cpu_addr,
  output logic                 cpu_stall,
  input  logic                 hit,
  input  logic                 lru_valid,
  input  logic                 lru_dirty,
  input  logic [TAG_W-1:0]     lru_tag,
  input  logic [LINE_BITS-1:0] cacheline_out,
  output logic                 addr_valid,
  output logic                 update_lru,
  output logic                 set_dirty,
  output logic                 clear_dirty,
  output logic                 set_valid,
  output logic                 clear_valid,
  output logic                 update_tag,
  output logic                 update_cacheline,
  output logic [LINE_BITS-1:0] cacheline_in,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack,
  output logic [CNT_W-1:0]     perf_hits,
  output logic [CNT_W-1:0]     perf_misses
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(LINE_WORDS - 1);

  ctrl_state_t              state_q;
  logic [BEAT_W-1:0]        beat_q;
  logic [31-OFFSET_W:0]     line_base_q;
  logic [INDEX_W-1:0]       index_q;
  logic [TAG_W-1:0]         wb_tag_q;
  logic [CNT_W-1:0]         hits_q;
  logic [CNT_W-1:0]         misses_q;

  logic req;
  logic miss;
  logic buf_load;
  logic buf_we;
  logic [WORD_W-1:0] buf_rdata;
  logic [LINE_BITS-1:0] buf_line;
  logic unused_offset;

  assign req           = cpu_read | cpu_write;
  assign miss          = (state_q == LOOKUP) && req && !hit;
  assign buf_load      = miss && lru_valid && lru_dirty;
  assign buf_we        = (state_q == FILL) && mem_ack;
  assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

  cache_line_buf #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .CLK        (CLK),
    .RST        (RST),
    .load       (buf_load),
    .load_line  (cacheline_out),
    .word_we    (buf_we),
    .word_idx   (beat_q),
    .word_wdata (mem_rdata),
    .word_rdata (buf_rdata),
    .line       (buf_line)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= LOOKUP;
      beat_q      <= '0;
      line_base_q <= '0;
      index_q     <= '0;
      wb_tag_q    <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
    end else begin
      unique case (state_q)
        LOOKUP: begin
          if (req && hit) begin
            if (hits_q != '1) hits_q <= hits_q + 1'b1;
          end else if (req) begin
            if (misses_q != '1) misses_q <= misses_q + 1'b1;
            line_base_q <= cpu_addr[31:OFFSET_W];
            index_q     <= cpu_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
            beat_q      <= '0;
            if (lru_valid && lru_dirty) begin
              wb_tag_q <= lru_tag;
              state_q  <= WB;
            end else begin
              state_q  <= FILL;
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            if (beat_q == LastBeat) begin
              beat_q  <= '0;
              state_q <= FILL;
            end else begin
              beat_q  <= beat_q + 1'b1;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            if (beat_q == LastBeat) begin
              beat_q  <= '0;
              state_q <= INSTALL;
            end else begin
              beat_q  <= beat_q + 1'b1;
            end
          end
        end
        INSTALL: state_q <= LOOKUP;
        default: state_q <= LOOKUP;
      endcase
    end
  end

  always_comb begin
    cpu_stall        = 1'b0;
    addr_valid       = 1'b0;
    update_lru       = 1'b0;
    set_dirty        = 1'b0;
    clear_dirty      = 1'b0;
    set_valid        = 1'b0;
    update_tag       = 1'b0;
    update_cacheline = 1'b0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    unique case (state_q)
      LOOKUP: begin
        // A simultaneous read and write is a store, so set_dirty follows cpu_write alone.
        if (req && hit) begin
          addr_valid = 1'b1;
          update_lru = 1'b1;
          set_dirty  = cpu_write;
        end
        cpu_stall = req && !hit;
      end
      WB: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_tag_q, index_q, beat_q, 2'b00};
        mem_wdata = buf_rdata;
      end
      FILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {line_base_q, beat_q, 2'b00};
      end
      INSTALL: begin
        cpu_stall        = 1'b1;
        update_cacheline = 1'b1;
        update_tag       = 1'b1;
        set_valid        = 1'b1;
        clear_dirty      = 1'b1;
      end
      default: cpu_stall = 1'b0;
    endcase
  end

  assign clear_valid  = 1'b0;
  assign cacheline_in = buf_line;
  assign perf_hits    = hits_q;
  assign perf_misses  = misses_q;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a scoreboard of expected memory
// beats and install lines, served by a simple acking memory model.
module tb_cache_controller;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic         CLK;
  logic         RST;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_addr;
  logic         cpu_stall;
  logic         hit, lru_valid, lru_dirty;
  logic [23:0]  lru_tag;
  logic [255:0] cacheline_out;
  logic         addr_valid, update_lru, set_dirty, clear_dirty, set_valid, clear_valid;
  logic         update_tag, update_cacheline;
  logic [255:0] cacheline_in;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack;
  logic [31:0]  perf_hits, perf_misses;

  beat_t        exp_q[$];
  logic [255:0] line_q[$];
  int           checks = 0;
  int           errors = 0;
  int           exp_hits = 0;
  int           exp_misses = 0;

  cache_controller #(
    .LINE_WORDS (8),
    .CNT_W      (32)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .cpu_read         (cpu_read),
    .cpu_write        (cpu_write),
    .cpu_addr         (cpu_addr),
    .cpu_stall        (cpu_stall),
    .hit              (hit),
    .lru_valid        (lru_valid),
    .lru_dirty        (lru_dirty),
    .lru_tag          (lru_tag),
    .cacheline_out    (cacheline_out),
    .addr_valid       (addr_valid),
    .update_lru       (update_lru),
    .set_dirty        (set_dirty),
    .clear_dirty      (clear_dirty),
    .set_valid        (set_valid),
    .clear_valid      (clear_valid),
    .update_tag       (update_tag),
    .update_cacheline (update_cacheline),
    .cacheline_in     (cacheline_in),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .perf_hits        (perf_hits),
    .perf_misses      (perf_misses)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_fill(input logic [31:0] base);
    beat_t        e;
    logic [255:0] l;
    for (int k = 0; k < 8; k++) begin
      e.we    = 1'b0;
      e.addr  = base + 32'(k * 4);
      e.wdata = '0;
      exp_q.push_back(e);
      l[k*32 +: 32] = rdata_of(e.addr);
    end
    line_q.push_back(l);
  endtask

  task automatic push_wb(input logic [23:0] tag, input logic [2:0] idx,
                         input logic [255:0] l);
    beat_t e;
    for (int k = 0; k < 8; k++) begin
      e.we    = 1'b1;
      e.addr  = {tag, idx, 3'(k), 2'b00};
      e.wdata = l[k*32 +: 32];
      exp_q.push_back(e);
    end
  endtask

  // Serve n beats from the scoreboard, acking each after 'delay' wait cycles.
  task automatic serve(input int n, input int delay);
    beat_t e;
    int    c;
    for (int i = 0; i < n; i++) begin
      c = 0;
      while (mem_req !== 1'b1 && c < 50) begin
        tick();
        c++;
      end
      checks++;
      if (mem_req !== 1'b1) begin
        errors++;
        $display("FAIL beat_timeout: mem_req=%b required 1 within 50 cycles", mem_req);
        return;
      end
      e = exp_q.pop_front();
      checks++;
      if (mem_addr !== e.addr || mem_we !== e.we || (e.we && mem_wdata !== e.wdata)) begin
        errors++;
        $display("FAIL beat%0d: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                 i, mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
      end
      for (int d = 0; d < delay; d++) begin
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL beat_hold: req=%b addr=%h required req=1 addr=%h",
                   mem_req, mem_addr, e.addr);
        end
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata_of(e.addr);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  endtask

  task automatic start_miss(input logic [31:0] a, input logic wr, input logic v,
                            input logic d, input logic [23:0] tag);
    tick();
    cpu_read  = !wr;
    cpu_write = wr;
    cpu_addr  = a;
    hit       = 1'b0;
    lru_valid = v;
    lru_dirty = d;
    lru_tag   = tag;
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || addr_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL miss_stall: stall=%b addr_valid=%b mem_req=%b required 1 0 0",
               cpu_stall, addr_valid, mem_req);
    end
    exp_misses++;
    tick();
  endtask

  // Check the install cycle, then let the stalled access hit in LOOKUP.
  task automatic install_and_hit(input logic stray_ack);
    logic [255:0] l;
    l = line_q.pop_front();
    checks++;
    if (update_cacheline !== 1'b1 || update_tag !== 1'b1 || set_valid !== 1'b1 ||
        clear_dirty !== 1'b1 || cpu_stall !== 1'b1 || mem_req !== 1'b0 || clear_valid !== 1'b0) begin
      errors++;
      $display("FAIL install_strobes: upd_line=%b upd_tag=%b set_valid=%b clr_dirty=%b stall=%b req=%b",
               update_cacheline, update_tag, set_valid, clear_dirty, cpu_stall, mem_req);
    end
    checks++;
    if (cacheline_in !== l) begin
      errors++;
      $display("FAIL install_line: cacheline_in=%h required %h", cacheline_in, l);
    end
    mem_ack = stray_ack;
    tick();
    mem_ack = 1'b0;
    hit     = 1'b1;
    #1;
    checks++;
    if (addr_valid !== 1'b1 || cpu_stall !== 1'b0 || update_lru !== 1'b1 ||
        set_dirty !== cpu_write || update_cacheline !== 1'b0) begin
      errors++;
      $display("FAIL post_install_hit: addr_valid=%b stall=%b lru=%b set_dirty=%b required 1 0 1 %b",
               addr_valid, cpu_stall, update_lru, set_dirty, cpu_write);
    end
    tick();
    exp_hits++;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    hit       = 1'b0;
    #1;
    checks++;
    if (perf_hits !== 32'(exp_hits) || perf_misses !== 32'(exp_misses)) begin
      errors++;
      $display("FAIL perf_counts: hits=%0d misses=%0d required %0d %0d",
               perf_hits, perf_misses, exp_hits, exp_misses);
    end
  endtask

  task automatic do_hit(input logic [31:0] a, input logic wr);
    tick();
    cpu_read  = !wr;
    cpu_write = wr;
    cpu_addr  = a;
    hit       = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || addr_valid !== 1'b1 || update_lru !== 1'b1 ||
        set_dirty !== wr || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL hit_%s: stall=%b addr_valid=%b lru=%b set_dirty=%b req=%b required 0 1 1 %b 0",
               wr ? "write" : "read", cpu_stall, addr_valid, update_lru, set_dirty, mem_req, wr);
    end
    tick();
    exp_hits++;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    hit       = 1'b0;
    #1;
    checks++;
    if (perf_hits !== 32'(exp_hits) || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL hit_count: perf_hits=%0d mem_req=%b required %0d 0",
               perf_hits, mem_req, exp_hits);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || addr_valid !== 1'b0 ||
        update_cacheline !== 1'b0 || perf_hits !== '0 || perf_misses !== '0) begin
      errors++;
      $display("FAIL reset_state: stall=%b req=%b we=%b upd=%b hits=%0d misses=%0d",
               cpu_stall, mem_req, mem_we, update_cacheline, perf_hits, perf_misses);
    end
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_read_miss_fill();
    push_fill(32'h0000_0100);
    start_miss(32'h0000_0104, 1'b0, 1'b0, 1'b0, 24'h0);
    serve(8, 0);
    install_and_hit(1'b0);
  endtask

  task automatic test_dirty_writeback();
    logic [255:0] victim;
    for (int k = 0; k < 8; k++) victim[k*32 +: 32] = $urandom;
    cacheline_out = victim;
    push_wb(24'h000001, 3'd0, victim);
    push_fill(32'h0000_0200);
    start_miss(32'h0000_0200, 1'b0, 1'b1, 1'b1, 24'h000001);
    cacheline_out = '0;
    serve(16, 0);
    install_and_hit(1'b0);
  endtask

  task automatic test_slow_ack_stray();
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || perf_misses !== 32'(exp_misses)) begin
      errors++;
      $display("FAIL stray_ack_idle: req=%b stall=%b misses=%0d required 0 0 %0d",
               mem_req, cpu_stall, perf_misses, exp_misses);
    end
    push_fill(32'h0000_0300);
    start_miss(32'h0000_0314, 1'b1, 1'b1, 1'b0, 24'h000002);
    serve(8, 3);
    install_and_hit(1'b1);
    // Stray ack during install must not disturb the next burst's start beat.
    push_fill(32'h0000_0340);
    start_miss(32'h0000_0340, 1'b0, 1'b0, 1'b0, 24'h0);
    serve(8, 0);
    install_and_hit(1'b0);
  endtask

  task automatic test_reset_mid_fill();
    push_fill(32'h0000_0400);
    start_miss(32'h0000_0400, 1'b0, 1'b0, 1'b0, 24'h0);
    serve(3, 0);
    exp_q.delete();
    line_q.delete();
    RST = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || update_cacheline !== 1'b0 || perf_misses !== '0) begin
      errors++;
      $display("FAIL reset_mid_fill: req=%b upd=%b misses=%0d required 0 0 0",
               mem_req, update_cacheline, perf_misses);
    end
    tick();
    checks++;
    if (update_cacheline !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: upd=%b req=%b required 0 0", update_cacheline, mem_req);
    end
    RST        = 1'b0;
    exp_hits   = 0;
    exp_misses = 1;
    push_fill(32'h0000_0400);
    tick();
    serve(8, 0);
    install_and_hit(1'b0);
  endtask

  initial begin
    RST           = 1'b1;
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    cpu_addr      = '0;
    hit           = 1'b0;
    lru_valid     = 1'b0;
    lru_dirty     = 1'b0;
    lru_tag       = '0;
    cacheline_out = '0;
    mem_rdata     = '0;
    mem_ack       = 1'b0;
    test_reset();
    test_read_miss_fill();
    do_hit(32'h0000_0108, 1'b0);
    do_hit(32'h0000_010C, 1'b1);
    test_dirty_writeback();
    test_slow_ack_stray();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
